// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - request synchronizer, sticky pending latch and encoder service handshake
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_in,
    input  logic [3:0] mask,
    output logic [3:0] enc_x,
    input  logic [1:0] enc_z,
    input  logic       enc_y,
    output logic       svc_valid,
    output logic [1:0] svc_idx,
    input  logic       svc_ready,
    output logic [3:0] pending,
    output logic [3:0] overrun,
    input  logic       clr_overrun
);

    typedef enum logic {
        IDLE,
        OFFER
    } state_t;

    state_t     state;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] hist_q;
    logic [3:0] sync_s;
    logic [3:0] req_edge;
    logic [3:0] clr_vec;
    logic [3:0] ovr_set;
    logic       fire;

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign req_edge = sync_s & ~hist_q;
    assign fire     = (state == OFFER) && svc_ready;
    assign enc_x    = pending & mask;

    always_comb begin
        clr_vec = 4'b0000;
        if (fire) begin
            clr_vec[svc_idx] = 1'b1;
        end
    end

    // A bit being serviced in the same cycle is not counted as lost
    assign ovr_set = req_edge & pending & ~clr_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= 4'b0000;
            end
            hist_q <= 4'b0000;
        end else begin
            sync_q[0] <= req_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            hist_q <= sync_s;
        end
    end

    // Clear then set: a fresh edge on the serviced bit keeps it pending
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= 4'b0000;
            overrun <= 4'b0000;
        end else begin
            pending <= (pending & ~clr_vec) | req_edge;
            if (clr_overrun) begin
                overrun <= ovr_set;
            end else begin
                overrun <= overrun | ovr_set;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            svc_valid <= 1'b0;
            svc_idx   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (enc_y) begin
                        svc_idx   <= enc_z;
                        svc_valid <= 1'b1;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (svc_ready) begin
                        svc_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    svc_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb/tb_irq_pending_latch.sv - directed bench for irq_pending_latch with a behavioural 4-input encoder
module tb_irq_pending_latch;

    logic       clk;
    logic       rst;
    logic [3:0] req_in;
    logic [3:0] mask;
    logic [3:0] enc_x;
    logic [1:0] enc_z;
    logic       enc_y;
    logic       svc_valid;
    logic [1:0] svc_idx;
    logic       svc_ready;
    logic [3:0] pending;
    logic [3:0] overrun;
    logic       clr_overrun;

    int checks;
    int passed;

    irq_pending_latch #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .mask       (mask),
        .enc_x      (enc_x),
        .enc_z      (enc_z),
        .enc_y      (enc_y),
        .svc_valid  (svc_valid),
        .svc_idx    (svc_idx),
        .svc_ready  (svc_ready),
        .pending    (pending),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    // Reference encoder: bit 3 highest priority
    always_comb begin
        enc_y = |enc_x;
        if (enc_x[3])      enc_z = 2'd3;
        else if (enc_x[2]) enc_z = 2'd2;
        else if (enc_x[1]) enc_z = 2'd1;
        else               enc_z = 2'd0;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (pending !== 4'b0000) $display("FAIL reset_pending got %b want 0000", pending); else passed++;
        checks++; if (overrun !== 4'b0000) $display("FAIL reset_overrun got %b want 0000", overrun); else passed++;
        checks++; if (svc_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", svc_valid); else passed++;
        checks++; if (svc_idx !== 2'd0) $display("FAIL reset_idx got %0d want 0", svc_idx); else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        req_in = 4'b0100;
        tick();                      // E1
        req_in = 4'b0000;
        tick();                      // E2
        checks++; if (pending !== 4'b0000) $display("FAIL single_pending_e2 got %b want 0000", pending); else passed++;
        tick();                      // E3
        checks++; if (pending !== 4'b0100) $display("FAIL single_pending_e3 got %b want 0100", pending); else passed++;
        checks++; if (svc_valid !== 1'b0) $display("FAIL single_valid_e3 got %b want 0", svc_valid); else passed++;
        tick();                      // E4
        checks++; if (svc_valid !== 1'b1) $display("FAIL single_valid_e4 got %b want 1", svc_valid); else passed++;
        checks++; if (svc_idx !== 2'd2) $display("FAIL single_idx_e4 got %0d want 2", svc_idx); else passed++;
        svc_ready = 1'b1;
        tick();
        checks++; if (pending !== 4'b0000) $display("FAIL single_pending_done got %b want 0000", pending); else passed++;
        checks++; if (svc_valid !== 1'b0) $display("FAIL single_valid_done got %b want 0", svc_valid); else passed++;
        svc_ready = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        svc_ready = 1'b1;
        req_in = 4'b0101;
        tick();
        req_in = 4'b0000;
        tick();
        tick();                      // E3
        checks++; if (pending !== 4'b0101) $display("FAIL b2b_pending got %b want 0101", pending); else passed++;
        tick();                      // E4
        checks++; if (svc_valid !== 1'b1 || svc_idx !== 2'd2) $display("FAIL b2b_first got v%b i%0d want v1 i2", svc_valid, svc_idx); else passed++;
        tick();                      // E5
        checks++; if (svc_valid !== 1'b0 || pending !== 4'b0001) $display("FAIL b2b_bubble got v%b p%b want v0 p0001", svc_valid, pending); else passed++;
        tick();                      // E6
        checks++; if (svc_valid !== 1'b1 || svc_idx !== 2'd0) $display("FAIL b2b_second got v%b i%0d want v1 i0", svc_valid, svc_idx); else passed++;
        tick();                      // E7
        checks++; if (svc_valid !== 1'b0 || pending !== 4'b0000) $display("FAIL b2b_done got v%b p%b want v0 p0000", svc_valid, pending); else passed++;
        svc_ready = 1'b0;
        tick();
    endtask

    task automatic test_mask();
        mask = 4'b0111;
        req_in = 4'b1010;
        tick();
        req_in = 4'b0000;
        tick();
        tick();                      // E3
        checks++; if (pending !== 4'b1010) $display("FAIL mask_pending got %b want 1010", pending); else passed++;
        checks++; if (enc_x !== 4'b0010) $display("FAIL mask_enc_x got %b want 0010", enc_x); else passed++;
        tick();                      // E4
        checks++; if (svc_valid !== 1'b1 || svc_idx !== 2'd1) $display("FAIL mask_offer got v%b i%0d want v1 i1", svc_valid, svc_idx); else passed++;
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        checks++; if (pending !== 4'b1000) $display("FAIL mask_after_svc got %b want 1000", pending); else passed++;
        tick();
        checks++; if (svc_valid !== 1'b0) $display("FAIL mask_hold_idle got %b want 0", svc_valid); else passed++;
        mask = 4'b1111;
        tick();
        checks++; if (svc_valid !== 1'b1 || svc_idx !== 2'd3) $display("FAIL mask_unmask_offer got v%b i%0d want v1 i3", svc_valid, svc_idx); else passed++;
    endtask

    task automatic test_overrun();
        int bad_hold;
        bad_hold = 0;
        req_in = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            req_in = 4'b0000;
            if (i == 2) mask = 4'b0111;
            if (svc_valid !== 1'b1 || svc_idx !== 2'd3) bad_hold++;
        end
        checks++; if (bad_hold !== 0) $display("FAIL ovr_offer_held got %0d bad cycles want 0", bad_hold); else passed++;
        checks++; if (overrun !== 4'b1000) $display("FAIL ovr_set got %b want 1000", overrun); else passed++;
        checks++; if (pending !== 4'b1000) $display("FAIL ovr_pending got %b want 1000", pending); else passed++;
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        checks++; if (overrun !== 4'b0000) $display("FAIL ovr_clear got %b want 0000", overrun); else passed++;
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        checks++; if (pending !== 4'b0000 || svc_valid !== 1'b0) $display("FAIL ovr_masked_complete got p%b v%b want p0000 v0", pending, svc_valid); else passed++;
        mask = 4'b1111;
        tick();
    endtask

    task automatic test_set_wins();
        req_in = 4'b0010;
        tick();                      // E1
        req_in = 4'b0000;
        tick();
        tick();
        tick();                      // E4 offer idx 1
        checks++; if (svc_valid !== 1'b1 || svc_idx !== 2'd1) $display("FAIL setwin_offer got v%b i%0d want v1 i1", svc_valid, svc_idx); else passed++;
        req_in = 4'b0010;
        tick();                      // E5
        req_in = 4'b0000;
        tick();                      // E6
        svc_ready = 1'b1;
        tick();                      // E7: handshake and new edge together
        svc_ready = 1'b0;
        checks++; if (pending !== 4'b0010) $display("FAIL setwin_pending got %b want 0010", pending); else passed++;
        checks++; if (overrun !== 4'b0000) $display("FAIL setwin_overrun got %b want 0000", overrun); else passed++;
        checks++; if (svc_valid !== 1'b0) $display("FAIL setwin_bubble got %b want 0", svc_valid); else passed++;
        tick();
        checks++; if (svc_valid !== 1'b1 || svc_idx !== 2'd1) $display("FAIL setwin_reoffer got v%b i%0d want v1 i1", svc_valid, svc_idx); else passed++;
        svc_ready = 1'b1;
        tick();
        svc_ready = 1'b0;
        checks++; if (pending !== 4'b0000) $display("FAIL setwin_done got %b want 0000", pending); else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        int offers;
        int bad_idx;
        offers = 0;
        bad_idx = 0;
        req_in = 4'b0100;
        tick();
        req_in = 4'b0000;
        tick();
        tick();
        tick();                      // offer idx 2
        req_in = 4'b0100;
        tick();
        req_in = 4'b0000;
        tick();
        tick();
        checks++; if (svc_valid !== 1'b1 || overrun !== 4'b0100) $display("FAIL rstmid_setup got v%b o%b want v1 o0100", svc_valid, overrun); else passed++;
        req_in = 4'b0001;
        rst = 1'b1;
        svc_ready = 1'b1;
        tick();
        checks++; if (svc_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", svc_valid); else passed++;
        checks++; if (pending !== 4'b0000) $display("FAIL rstmid_pending got %b want 0000", pending); else passed++;
        checks++; if (overrun !== 4'b0000) $display("FAIL rstmid_overrun got %b want 0000", overrun); else passed++;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (svc_valid === 1'b1) begin
                offers++;
                if (svc_idx !== 2'd0) bad_idx++;
            end
        end
        checks++; if (offers !== 1) $display("FAIL rstmid_one_service got %0d want 1", offers); else passed++;
        checks++; if (bad_idx !== 0) $display("FAIL rstmid_idx got %0d wrong want 0", bad_idx); else passed++;
        checks++; if (pending !== 4'b0000) $display("FAIL rstmid_final_pending got %b want 0000", pending); else passed++;
        svc_ready = 1'b0;
        req_in = 4'b0000;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst = 1'b1;
        req_in = 4'b0000;
        mask = 4'b1111;
        svc_ready = 1'b0;
        clr_overrun = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_mask();
        test_overrun();
        test_set_wins();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
Upstream stage of the 4-input priority encoder (encoder_x4, bit 3 highest priority). It has three jobs:
- Synchronize four raw request lines and turn their rising edges into sticky pending bits.
- Drive the masked pending vector into the encoder.
- Hold the encoder's winning index in a valid/ready service handshake, and clear the serviced pending bit on acceptance.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per request line (legal range 1..3).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req_in  input  4  raw request lines, asynchronous to clk.
mask  input  4  per-bit enable; 1 = bit may be presented to the encoder.
enc_x  output  4  to encoder input x; equals pending & mask (combinational).
enc_z  input  2  from encoder output z; index of highest set bit of enc_x.
enc_y  input  1  from encoder control y; 1 when enc_x != 0.
svc_valid  output  1  a serviced index is offered.
svc_idx  output  2  offered index; stable while svc_valid=1.
svc_ready  input  1  consumer accepts the offer when high together with svc_valid.
pending  output  4  current pending register.
overrun  output  4  sticky; bit set when a new edge arrives on an already-pending bit.
clr_overrun  input  1  synchronous clear of the overrun register.

Behaviour:
- Reset (rst=1 at an edge) clears all of the following. Reset takes priority over every other event, including mid-handshake; an in-flight offer is dropped.
  - Sync chains, edge-history flop, pending, overrun, svc_idx: all 0.
  - FSM returns to IDLE; svc_valid=0.
- Synchronizer: req_in -> SYNC_STAGES flops -> s. The history flop h <= s. edge[i] = s[i] & ~h[i].
  - A line held high through reset release yields exactly one edge.
- Pending update per bit i, applied each edge in this order:
  - clear if the handshake fires on index i this cycle;
  - then set if edge[i].
  - Result: a simultaneous set and clear leaves the bit 1 (set wins).
- Overrun[i] is set when edge[i]=1 and pending[i]=1 before the update.
  - Exception: a same-cycle clear of bit i is not an overrun.
  - clr_overrun=1 clears all overrun bits. A new overrun in that same cycle wins (bit stays 1).
- Mask is applied only on enc_x. Masked bits stay pending and keep collecting edges.
- FSM:
  - IDLE: svc_valid=0. If enc_y=1: svc_idx <= enc_z, svc_valid <= 1, go to OFFER.
  - OFFER: svc_valid=1 and svc_idx held regardless of changes to mask, enc_x or enc_z (no retraction).
    - If svc_ready=1: clear pending[svc_idx], svc_valid <= 0, go to IDLE.
    - If svc_ready=0: remain in OFFER.
  - Throughput is at most one service per 2 cycles (one bubble in IDLE).
  - If the offered bit becomes masked during OFFER, the offer completes normally.
- Latency with SYNC_STAGES=2: req_in high before edge E1 gives
  - pending set after E3;
  - svc_valid=1 after E4 (if the bit is unmasked and no offer is in progress).
- Priority is inherited from the encoder: index 3 > 2 > 1 > 0.
- The block does not check that enc_z/enc_y are consistent with enc_x; the encoder is trusted.

Test Plan:
1. Reset, mask=4'b1111, pulse req_in=4'b0100 for 1 cycle.
   -> pending=4'b0100 after E3; svc_valid=1, svc_idx=2'b10 after E4; svc_ready=1 -> pending=0, svc_valid=0 next edge.
2. req_in=4'b0101 in the same cycle, svc_ready held 1.
   -> svc_idx=2 served first, then svc_idx=0 two cycles later; pending ends at 4'b0000.
3. pending=4'b1010 with mask=4'b0111.
   -> svc_idx=1 only; bit 3 stays pending; raise mask[3] -> svc_idx=3 offered next.
4. OFFER on idx 3 with svc_ready=0 for 5 cycles, and a second req_in[3] edge arrives.
   -> svc_idx stays 3; overrun=4'b1000; clr_overrun clears it to 4'b0000.
5. New edge on bit 1 in the same cycle its handshake fires.
   -> pending[1]=1 afterwards; overrun[1]=0; svc_idx=1 offered again.
6. rst asserted while svc_valid=1.
   -> next edge: svc_valid=0, pending=0, overrun=0; req_in held at 4'b0001 through reset -> exactly one new service of idx 0.
